vmem_arbiter: RTL

VMEM_ARBITER -- requirements
Module: vmem_arbiter

---
 rtl/vmem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - single-port video RAM arbiter: VGA fetch > screen clear > CPU access
module vmem_arbiter #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter logic [11:0] CMD_ADDR  = 12'h07F
) (
  input  logic        clk50_in,
  input  logic        rst_n,
  input  logic        vga_ren,
  input  logic [11:0] vga_addr,
  output logic [7:0]  vga_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_cx;
  logic [4:0] r_cy;
  logic       r_cpu_pending;
  logic       r_cpu_rd;
  logic       r_clear_done;

  logic w_is_cmd, w_cpu_grant, w_start_clear, w_clear_wr, w_last_wr;

  // rst_n gates the grant so a held cpu_req cannot reach the RAM port during reset
  assign w_is_cmd      = (cpu_addr == CMD_ADDR);
  assign w_cpu_grant   = rst_n && cpu_req && !vga_ren && (r_state == S_IDLE) && !r_cpu_pending;
  assign w_start_clear = w_cpu_grant && cpu_we && w_is_cmd && cpu_wdata[0];
  assign w_clear_wr    = (r_state == S_CLEAR) && !vga_ren;
  assign w_last_wr     = w_clear_wr && (r_cx == LAST_X) && (r_cy == LAST_Y);

  always_ff @(posedge clk50_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_clear) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_last_wr)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cursor walks row-major over the visible area only; it lands back on 0,0 after the last cell
  always_ff @(posedge clk50_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= 7'd0;
      r_cy <= 5'd0;
    end else if (w_start_clear) begin
      r_cx <= 7'd0;
      r_cy <= 5'd0;
    end else if (w_clear_wr) begin
      if (r_cx == LAST_X) begin
        r_cx <= 7'd0;
        r_cy <= (r_cy == LAST_Y) ? 5'd0 : r_cy + 5'd1;
      end else begin
        r_cx <= r_cx + 7'd1;
      end
    end
  end

  always_ff @(posedge clk50_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_pending <= 1'b0;
      r_cpu_rd      <= 1'b0;
      r_clear_done  <= 1'b0;
    end else begin
      r_cpu_pending <= w_cpu_grant;
      r_cpu_rd      <= w_cpu_grant && !cpu_we && !w_is_cmd;
      r_clear_done  <= w_last_wr;
    end
  end

  assign cpu_ack    = r_cpu_pending;
  assign cpu_rdata  = r_cpu_rd ? mem_dout : 8'h00;
  assign clear_busy = (r_state == S_CLEAR);
  assign clear_done = r_clear_done;
  assign vga_data   = mem_dout;

  always_comb begin
    mem_addr = 12'h000;
    mem_we   = 1'b0;
    mem_din  = 8'h00;
    if (vga_ren) begin
      mem_addr = vga_addr;
    end else if (r_state == S_CLEAR) begin
      mem_addr = {r_cy, r_cx};
      mem_we   = 1'b1;
      mem_din  = FILL_CHAR;
    end else if (w_cpu_grant) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we && !w_is_cmd;
      mem_din  = cpu_wdata;
    end
  end

endmodule
